// File: rtl/fmt2_sequencer.sv
// fmt2_sequencer: control stage for MSP430 format II shift-class instructions
// (RRC, SWPB, RRA, SXT). Fetches the operand for the As addressing mode, drives
// the external combinational shifter, and writes back the result and SR flags.
// Byte reads return the addressed byte in mem_rdata[7:0]; byte writes carry the
// byte in mem_wdata[7:0].
module fmt2_sequencer #(
  parameter int SIZE_BYTE = 8,
  parameter int SIZE_WORD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [15:0]          instr,
  output logic [3:0]           rf_raddr,
  input  logic [SIZE_WORD-1:0] rf_rdata,
  output logic [3:0]           rf_waddr,
  output logic [SIZE_WORD-1:0] rf_wdata,
  output logic                 rf_we,
  input  logic                 sr_c,
  output logic [3:0]           sr_flags_we,
  output logic [3:0]           sr_flags,
  output logic [SIZE_WORD-1:0] mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 mem_bw,
  output logic [SIZE_WORD-1:0] mem_wdata,
  input  logic [SIZE_WORD-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic [1:0]           sh_fs,
  output logic                 sh_bw,
  output logic [SIZE_WORD-1:0] sh_dst,
  input  logic [SIZE_WORD-1:0] sh_out,
  input  logic [3:0]           sh_cvnz,
  output logic                 done,
  output logic                 illegal
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, EXT = 3'd1, RD = 3'd2, INC = 3'd3, EXEC = 3'd4, WB = 3'd5
  } state_t;

  localparam logic [1:0] OPC_RRC  = 2'b00;
  localparam logic [1:0] OPC_SWPB = 2'b01;
  localparam logic [1:0] OPC_RRA  = 2'b10;
  localparam logic [1:0] OPC_SXT  = 2'b11;

  localparam logic [SIZE_WORD-1:0] ZERO_W = {SIZE_WORD{1'b0}};
  localparam logic [SIZE_WORD-SIZE_BYTE-1:0] ZERO_HI = {(SIZE_WORD-SIZE_BYTE){1'b0}};

  state_t               state_r, state_nxt_s;
  logic [1:0]           opc_r, as_r;
  logic                 bw_r, cg_r, illegal_r;
  logic [3:0]           rn_r, flags_r;
  logic [SIZE_WORD-1:0] rn_val_r, ea_r, opnd_r, res_r;

  logic                 bad_s, cg_s, zero_s, wb_done_s;
  logic [SIZE_WORD-1:0] cg_val_s, res_s, wb_data_s, step_s;
  logic [3:0]           flags_s, flag_mask_s;
  logic                 unused_v_flag;

  // Word accesses are always even-aligned; byte accesses keep bit 0.
  function automatic logic [SIZE_WORD-1:0] bus_addr(input logic [SIZE_WORD-1:0] a,
                                                    input logic bw);
    bus_addr = bw ? a : {a[SIZE_WORD-1:1], 1'b0};
  endfunction

  // The shifter's V output is never used: V is always written as 0.
  assign unused_v_flag = sh_cvnz[2];

  // Decode of the presented word: legality and constant-generator operand.
  always_comb begin
    // opc >= 100 has bit 9 set; SWPB/SXT (001/011) are the legal opcodes with bit 7 set.
    bad_s    = (instr[15:10] != 6'b000100) || instr[9] || (instr[6] && instr[7]);
    cg_s     = (instr[3:0] == 4'd3) || ((instr[3:0] == 4'd2) && instr[5]);
    cg_val_s = ZERO_W;
    if (instr[3:0] == 4'd3) begin
      case (instr[5:4])
        2'b00:   cg_val_s = 16'h0000;
        2'b01:   cg_val_s = 16'h0001;
        2'b10:   cg_val_s = 16'h0002;
        default: cg_val_s = 16'hFFFF;
      endcase
    end else begin
      case (instr[5:4])
        2'b11:   cg_val_s = 16'h0008;
        default: cg_val_s = 16'h0004;
      endcase
    end
  end

  // Result fix-up (RRC carry-in) and flag values for the EXEC cycle.
  always_comb begin
    res_s = sh_out;
    if (opc_r == OPC_RRC) begin
      if (bw_r) res_s[SIZE_BYTE-1] = sr_c;
      else      res_s[SIZE_WORD-1] = sr_c;
    end else begin
      res_s = sh_out;
    end
    zero_s = bw_r ? (res_s[SIZE_BYTE-1:0] == {SIZE_BYTE{1'b0}}) : (res_s == ZERO_W);
    case (opc_r)
      OPC_RRC: flags_s = {sh_cvnz[3], 1'b0, sr_c, zero_s};
      OPC_RRA: flags_s = {sh_cvnz[3], 1'b0, sh_cvnz[1], sh_cvnz[0]};
      OPC_SXT: flags_s = {~sh_cvnz[0], 1'b0, sh_cvnz[1], sh_cvnz[0]};
      default: flags_s = 4'b0000;
    endcase
    flag_mask_s = (opc_r == OPC_SWPB) ? 4'b0000 : 4'b1111;
  end

  assign step_s    = (bw_r && (rn_r != 4'd1)) ? 16'h0001 : 16'h0002;
  assign wb_data_s = bw_r ? {ZERO_HI, res_r[SIZE_BYTE-1:0]} : res_r;
  // Register and constant-generator writebacks finish at once; memory waits for ack.
  assign wb_done_s = (state_r == WB) && (cg_r || (as_r == 2'b00) || mem_ack);

  assign done        = wb_done_s;
  assign illegal     = illegal_r;
  assign sr_flags_we = wb_done_s ? flag_mask_s : 4'b0000;
  assign sr_flags    = wb_done_s ? flags_r : 4'b0000;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!instr_valid || bad_s) state_nxt_s = IDLE;
        else if (cg_s)             state_nxt_s = EXEC;
        else begin
          case (instr[5:4])
            2'b00:   state_nxt_s = EXEC;
            2'b01:   state_nxt_s = EXT;
            default: state_nxt_s = RD;
          endcase
        end
      end
      EXT:     state_nxt_s = mem_ack ? RD : EXT;
      RD: begin
        if (mem_ack) state_nxt_s = (as_r == 2'b11) ? INC : EXEC;
        else         state_nxt_s = RD;
      end
      INC:     state_nxt_s = EXEC;
      EXEC:    state_nxt_s = WB;
      WB:      state_nxt_s = wb_done_s ? IDLE : WB;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath registers: field latch at acceptance, EA, operand, result, flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opc_r <= 2'b00; as_r <= 2'b00; bw_r <= 1'b0; cg_r <= 1'b0; rn_r <= 4'd0;
      rn_val_r <= ZERO_W; ea_r <= ZERO_W; opnd_r <= ZERO_W; res_r <= ZERO_W;
      flags_r <= 4'b0000; illegal_r <= 1'b0;
    end else begin
      illegal_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (instr_valid) begin
            illegal_r <= bad_s;
            opc_r     <= instr[8:7];
            bw_r      <= instr[6];
            as_r      <= instr[5:4];
            rn_r      <= instr[3:0];
            cg_r      <= cg_s;
            rn_val_r  <= rf_rdata;
            ea_r      <= rf_rdata;
            opnd_r    <= cg_s ? cg_val_s : rf_rdata;
          end
        end
        EXT: begin
          if (mem_ack) ea_r <= mem_rdata + ((rn_r == 4'd2) ? ZERO_W : rn_val_r);
        end
        RD: begin
          if (mem_ack) opnd_r <= bw_r ? {ZERO_HI, mem_rdata[SIZE_BYTE-1:0]} : mem_rdata;
        end
        EXEC: begin
          res_r   <= res_s;
          flags_r <= flags_s;
        end
        default: ;
      endcase
    end
  end

  // Output decode per state: register file, memory and shifter controls.
  always_comb begin
    instr_ready = 1'b0;
    rf_raddr    = 4'd0;
    rf_waddr    = 4'd0;
    rf_wdata    = ZERO_W;
    rf_we       = 1'b0;
    mem_addr    = ZERO_W;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_bw      = 1'b0;
    mem_wdata   = ZERO_W;
    sh_fs       = 2'b00;
    sh_bw       = 1'b0;
    sh_dst      = ZERO_W;
    case (state_r)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) rf_raddr = instr[3:0];
        else             rf_raddr = 4'd0;
      end
      EXT: begin
        // Extension word lives at PC; PC advances past it when it arrives.
        rf_raddr = 4'd0;
        mem_rd   = 1'b1;
        mem_addr = bus_addr(rf_rdata, 1'b0);
        if (mem_ack) begin
          rf_we    = 1'b1;
          rf_waddr = 4'd0;
          rf_wdata = rf_rdata + 16'h0002;
        end else begin
          rf_we = 1'b0;
        end
      end
      RD: begin
        mem_rd   = 1'b1;
        mem_bw   = bw_r;
        mem_addr = bus_addr(ea_r, bw_r);
      end
      INC: begin
        rf_we    = 1'b1;
        rf_waddr = rn_r;
        rf_wdata = rn_val_r + step_s;
      end
      EXEC: begin
        sh_fs  = {opc_r[0], opc_r[1]};
        sh_bw  = bw_r;
        sh_dst = opnd_r;
      end
      WB: begin
        if (cg_r) begin
          rf_we = 1'b0;
        end else if (as_r == 2'b00) begin
          rf_we    = 1'b1;
          rf_waddr = rn_r;
          rf_wdata = wb_data_s;
        end else begin
          mem_wr    = 1'b1;
          mem_bw    = bw_r;
          mem_addr  = bus_addr(ea_r, bw_r);
          mem_wdata = wb_data_s;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fmt2_sequencer.sv
// tb_fmt2_sequencer: table-driven register/constant-generator vectors plus
// hand-written memory-mode, reset and illegal sequences. Writes, flag updates,
// done and illegal pulses are checked against a scoreboard queue.
module tb_fmt2_sequencer;

  logic        clk, rst, instr_valid, instr_ready;
  logic [15:0] instr, rf_rdata, rf_wdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] sh_dst, sh_out;
  logic [3:0]  rf_raddr, rf_waddr, sr_flags_we, sr_flags, sh_cvnz;
  logic        rf_we, sr_c, mem_rd, mem_wr, mem_bw, mem_ack, sh_bw, done, illegal;
  logic [1:0]  sh_fs;

  fmt2_sequencer #(.SIZE_BYTE(8), .SIZE_WORD(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_we(rf_we), .sr_c(sr_c), .sr_flags_we(sr_flags_we),
    .sr_flags(sr_flags), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_bw(mem_bw), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .sh_fs(sh_fs), .sh_bw(sh_bw), .sh_dst(sh_dst), .sh_out(sh_out), .sh_cvnz(sh_cvnz),
    .done(done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ack_delay = 0;
  int wcnt = 0;
  logic [15:0] regs [0:15];
  logic [7:0]  mem  [0:65535];

  // kinds: 0 rf write, 1 word mem write, 2 flags, 3 done, 4 illegal, 5 byte mem write
  typedef struct packed { logic [2:0] kind; logic [15:0] a; logic [15:0] d; } ev_t;
  ev_t expq[$];

  assign rf_rdata = regs[rf_raddr];

  // Reference shifter: RRC without carry-in (MSB 0), RRA, SWPB, SXT.
  function automatic logic [19:0] shift_model(input logic [1:0] fs, input logic bw,
                                              input logic [15:0] d);
    logic [15:0] o;
    logic c, n, z;
    case (fs)
      2'b00:   begin o = bw ? {8'h00, 1'b0, d[7:1]} : {1'b0, d[15:1]}; c = d[0]; end
      2'b01:   begin o = bw ? {8'h00, d[7], d[7:1]} : {d[15], d[15:1]}; c = d[0]; end
      2'b10:   begin o = {d[7:0], d[15:8]}; c = 1'b0; end
      default: begin o = {{8{d[7]}}, d[7:0]}; c = 1'b0; end
    endcase
    n = bw ? o[7] : o[15];
    z = bw ? (o[7:0] == 8'h00) : (o == 16'h0000);
    return {c, 1'b0, n, z, o};
  endfunction

  assign {sh_cvnz, sh_out} = shift_model(sh_fs, sh_bw, sh_dst);

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic [15:0] a, input logic [15:0] d);
    expq.push_back('{kind: k, a: a, d: d});
  endtask

  task automatic obs(input logic [2:0] k, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    tests++;
    if (expq.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind=%0d a=%h d=%h expected none", k, a, d);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || e.a != a || e.d != d) begin
        fails++;
        $display("FAIL event: got kind=%0d a=%h d=%h expected kind=%0d a=%h d=%h",
                 k, a, d, e.kind, e.a, e.d);
      end
    end
  endtask

  // Memory responder: acks after ack_delay wait cycles, one ack per access.
  always @(negedge clk) begin
    if (rst) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else begin
      if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end
      if (mem_rd || mem_wr) begin
        if (wcnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_bw) mem_rdata = {8'h00, mem[mem_addr]};
          else        mem_rdata = {mem[mem_addr | 16'h0001], mem[mem_addr & 16'hFFFE]};
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Register file and memory commit on the clock edge.
  always @(posedge clk) begin
    if (!rst) begin
      if (rf_we) regs[rf_waddr] <= rf_wdata;
      if (mem_wr && mem_ack) begin
        if (mem_bw) mem[mem_addr] <= mem_wdata[7:0];
        else begin
          mem[mem_addr & 16'hFFFE] <= mem_wdata[7:0];
          mem[mem_addr | 16'h0001] <= mem_wdata[15:8];
        end
      end
    end
  end

  // Output monitor: every observed write/pulse is matched against the scoreboard.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (rf_we) obs(3'd0, {12'h000, rf_waddr}, rf_wdata);
      if (mem_wr && mem_ack) obs(mem_bw ? 3'd5 : 3'd1, mem_addr, mem_wdata);
      if (sr_flags_we != 4'b0000) obs(3'd2, {12'h000, sr_flags_we}, {12'h000, sr_flags});
      if (done) obs(3'd3, 16'h0000, 16'h0000);
      if (illegal) obs(3'd4, 16'h0000, 16'h0000);
    end
  end

  // Present one word, wait for acceptance, then count cycles to done/illegal.
  task automatic issue(input logic [15:0] w, output int lat);
    bit seen;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    #1;
    chk("ready_before_accept", {31'd0, instr_ready}, 32'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      #1;
      lat++;
      if (done || illegal) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL retire_timeout: got no done/illegal after %0d cycles expected retirement", lat);
    end
  endtask

  typedef struct packed {
    logic [15:0] w; logic [15:0] v; logic c; logic wr;
    logic [15:0] r; logic [3:0] we; logic [3:0] f;
  } vec_t;
  vec_t tbl [14];

  initial begin
    int lat;
    tbl[0]  = '{16'h1005, 16'h8001, 1'b1, 1'b1, 16'hC000, 4'hF, 4'hA}; // RRC.W R5
    tbl[1]  = '{16'h1045, 16'h1234, 1'b0, 1'b1, 16'h001A, 4'hF, 4'h0}; // RRC.B R5
    tbl[2]  = '{16'h1109, 16'h8002, 1'b0, 1'b1, 16'hC001, 4'hF, 4'h2}; // RRA.W R9
    tbl[3]  = '{16'h1109, 16'h0001, 1'b0, 1'b1, 16'h0000, 4'hF, 4'h9}; // RRA.W R9 -> 0
    tbl[4]  = '{16'h108A, 16'h1234, 1'b0, 1'b1, 16'h3412, 4'h0, 4'h0}; // SWPB R10
    tbl[5]  = '{16'h118B, 16'h0080, 1'b0, 1'b1, 16'hFF80, 4'hF, 4'hA}; // SXT R11
    tbl[6]  = '{16'h118B, 16'h7F00, 1'b0, 1'b1, 16'h0000, 4'hF, 4'h1}; // SXT R11 -> 0
    tbl[7]  = '{16'h1004, 16'h0000, 1'b0, 1'b1, 16'h0000, 4'hF, 4'h1}; // RRC.W R4 zero
    tbl[8]  = '{16'h1044, 16'hFF01, 1'b1, 1'b1, 16'h0080, 4'hF, 4'hA}; // RRC.B R4 carry in
    tbl[9]  = '{16'h114C, 16'h00FE, 1'b0, 1'b1, 16'h00FF, 4'hF, 4'h2}; // RRA.B R12
    tbl[10] = '{16'h1183, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'hF, 4'h1}; // SXT R3 (#0)
    tbl[11] = '{16'h1133, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'hF, 4'hA}; // RRA #-1
    tbl[12] = '{16'h1022, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'hF, 4'h0}; // RRC #4
    tbl[13] = '{16'h1013, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h9}; // RRC #1 (c ignored? no: inserted)

    // RRC #1 with sr_c=1: 1>>1=0, C=1, MSB<-1 -> 0x8000, N=1 Z=0.
    tbl[13].f = 4'hA;

    for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000; sr_c = 1'b0;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", {31'd0, instr_ready}, 32'd1);
    chk("reset_outputs_zero",
        {31'd0, |{rf_raddr, rf_waddr, rf_wdata, rf_we, sr_flags_we, sr_flags, mem_addr,
                  mem_rd, mem_wr, mem_bw, mem_wdata, sh_fs, sh_bw, sh_dst, done, illegal}},
        32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Register and constant-generator vectors: done exactly 2 cycles after acceptance.
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) regs[tbl[i].w[3:0]] = tbl[i].v;
      sr_c = tbl[i].c;
      if (tbl[i].wr) push(3'd0, {12'h000, tbl[i].w[3:0]}, tbl[i].r);
      if (tbl[i].we != 4'h0) push(3'd2, {12'h000, tbl[i].we}, {12'h000, tbl[i].f});
      push(3'd3, 16'h0000, 16'h0000);
      issue(tbl[i].w, lat);
      chk($sformatf("latency_vec%0d", i), lat, 32'd2);
      @(posedge clk);
      #1;
      if (tbl[i].wr) chk($sformatf("rf_after_vec%0d", i), {16'h0, regs[tbl[i].w[3:0]]}, {16'h0, tbl[i].r});
    end
    sr_c = 1'b0;

    // RRA.B @R6+ : byte read, R6+=1, byte write 0xC0 back to 0x0200.
    ack_delay = 0;
    regs[6] = 16'h0200;
    mem[16'h0200] = 8'h81;
    push(3'd0, 16'h0006, 16'h0201);
    push(3'd5, 16'h0200, 16'h00C0);
    push(3'd2, 16'h000F, 16'h000A);
    push(3'd3, 16'h0000, 16'h0000);
    issue(16'h1176, lat);
    chk("latency_rra_b_postinc", lat, 32'd4);
    @(posedge clk);
    #1;
    chk("mem_0200", {24'h0, mem[16'h0200]}, 32'h000000C0);
    chk("r6_after", {16'h0, regs[6]}, 32'h00000201);

    // SWPB X(R7) with one wait cycle per access.
    ack_delay = 1;
    regs[0] = 16'h4000;
    mem[16'h4000] = 8'h10; mem[16'h4001] = 8'h00;
    regs[7] = 16'h0300;
    mem[16'h0310] = 8'h34; mem[16'h0311] = 8'h12;
    push(3'd0, 16'h0000, 16'h4002);
    push(3'd1, 16'h0310, 16'h3412);
    push(3'd3, 16'h0000, 16'h0000);
    issue(16'h1097, lat);
    chk("latency_swpb_indexed", lat, 32'd7);
    @(posedge clk);
    #1;
    chk("mem_0310_word", {16'h0, mem[16'h0311], mem[16'h0310]}, 32'h00003412);
    chk("pc_after_ext", {16'h0, regs[0]}, 32'h00004002);

    // RRA.W @R8 with no ack: RD controls held steady, then reset abandons it.
    ack_delay = 1000;
    regs[8] = 16'h0401;
    @(negedge clk);
    instr = 16'h1128;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rd_hold_c%0d", k + 1), {13'd0, mem_rd, mem_bw, mem_wr, mem_addr},
          {13'd0, 1'b1, 1'b0, 1'b0, 16'h0400});
      chk($sformatf("busy_not_ready_c%0d", k + 1), {31'd0, instr_ready}, 32'd0);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_mid_strobes", {25'd0, rf_we, mem_rd, mem_wr, |sr_flags_we, done, illegal, 1'b0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    repeat (6) @(negedge clk);
    #1;
    chk("r8_untouched", {16'h0, regs[8]}, 32'h00000401);
    chk("idle_after_rst", {31'd0, instr_ready}, 32'd1);

    // Illegal words: PUSH and SXT.B.
    push(3'd4, 16'h0000, 16'h0000);
    issue(16'h1205, lat);
    chk("illegal_push_latency", lat, 32'd1);
    chk("illegal_push_ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    #1;
    chk("illegal_push_one_cycle", {31'd0, illegal}, 32'd0);
    push(3'd4, 16'h0000, 16'h0000);
    issue(16'h11C4, lat);
    chk("illegal_sxtb_latency", lat, 32'd1);
    chk("illegal_sxtb_ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    #1;
    chk("illegal_sxtb_one_cycle", {31'd0, illegal}, 32'd0);
    chk("r4_after_illegal", {16'h0, regs[4]}, 32'h00000080);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", expq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/fmt2_sequencer.md
Name: fmt2_sequencer

Overview:
- Multi-cycle control stage for MSP430 single-operand (format II) shift-class instructions: RRC, SWPB, RRA, SXT.
- Accepts a decoded instruction word and fetches the operand according to the As addressing mode. Drives the combinational shifter, applies the RRC carry-in, then writes back the result and status flags.
- Sits between instruction fetch and the register file / data memory, directly upstream of the shifter, and consumes its result.

Parameters:
- SIZE_BYTE, 8, byte operand width
- SIZE_WORD, 16, word operand / address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- instr_valid  in  1  instruction word present
- instr_ready  out  1  sequencer idle, accepts instruction
- instr  in  16  format II word: [15:10]=000100, [9:7]=opc, [6]=BW, [5:4]=As, [3:0]=Rn
- rf_raddr  out  4  register read address (rf_rdata is combinational)
- rf_rdata  in  16  register read data
- rf_waddr  out  4  register write address
- rf_wdata  out  16  register write data
- rf_we  out  1  register write strobe
- sr_c  in  1  current SR carry
- sr_flags_we  out  4  per-flag write enable {C,V,N,Z}
- sr_flags  out  4  new flag values {C,V,N,Z}
- mem_addr  out  16  data memory address
- mem_rd  out  1  read request
- mem_wr  out  1  write request
- mem_bw  out  1  byte access
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid with mem_ack
- mem_ack  in  1  access complete
- sh_fs  out  2  shifter function: RRC=00, RRA=01, SWPB=10, SXT=11
- sh_bw  out  1  shifter byte mode
- sh_dst  out  16  shifter operand
- sh_out  in  16  shifter result
- sh_cvnz  in  4  shifter flags {C,V,N,Z}
- done  out  1  one-cycle pulse, instruction retired
- illegal  out  1  one-cycle pulse, instruction rejected

Behaviour:
- Reset (asynchronous) values: state=IDLE, instr_ready=1. All strobes, done and illegal are 0. All data and address outputs are 0. Reset mid-operation abandons the instruction with no further rf, memory or SR writes.
- opc decode: 000 RRC, 001 SWPB, 010 RRA, 011 SXT.
- Rejected instructions: opc of 100 or above, or SWPB/SXT with BW=1.
  - illegal pulses in the cycle after the handshake.
  - No writes occur; the FSM returns to IDLE.
- Handshake: an instruction is accepted when instr_valid and instr_ready are both high. Fields are latched at acceptance; instr_ready=0 until return to IDLE.
- States: IDLE, EXT, RD, INC, EXEC, WB.
- Transitions:
  - IDLE to EXT when As=01.
  - IDLE to RD when As=10 or 11.
  - IDLE to EXEC when As=00.
  - Constant-generator case: Rn=R3 (any As), or Rn=R2 with As=10 or 11. Go to EXEC with operand 0, 4, 8, 1, 2 or -1 per MSP430 CG rules. Writeback is suppressed; flags are still written.
- EXT: reads the index word at address R0 (mem_rd, word access).
  - On mem_ack: EA = index + Rn. For Rn=R2, EA = index (absolute mode).
  - Also writes R0 = R0+2 (rf_we), then goes to RD.
- RD: mem_rd=1, with mem_addr=EA (or Rn for indirect modes).
  - mem_addr, mem_bw and mem_rd are held stable until mem_ack.
  - Word access forces address bit0=0.
  - Operand is latched on mem_ack. Next state is INC for As=11, otherwise EXEC.
- INC: Rn += 1 for byte access, += 2 for word access. R1 always increments by 2. Then EXEC.
- EXEC: drive sh_fs, sh_bw and sh_dst, then capture the result.
  - RRC: the MSB of the result (bit 15, or bit 7 in byte mode) is replaced by sr_c. N is the inserted bit; Z is recomputed.
- WB:
  - Register modes: rf write Rn. Byte mode clears bits 15:8.
  - Memory modes: mem_wr to the latched EA, held until mem_ack.
  - done pulses in the cycle WB completes; the FSM returns to IDLE.
- Flag rules:
  - RRC, RRA: write C, N, Z from the result; V=0.
  - SXT: write N and Z; C = ~Z; V=0.
  - SWPB: sr_flags_we=0.
- Latency: register mode has done exactly 2 cycles after acceptance. Memory modes add one cycle per state plus ack wait cycles.
- At most one rf write per cycle.

Test Plan:
1. RRC.W R5 (0x1005), R5=0x8001, sr_c=1 -> R5=0xC000, flags C=1 V=0 N=1 Z=0, done 2 cycles after acceptance.
2. RRA.B @R6+ (0x1176), R6=0x0200, mem byte[0x0200]=0x81 -> byte write 0xC0 to 0x0200, R6=0x0201, C=1 N=1 Z=0.
3. SWPB X(R7) (0x1097), index word 0x0010, R7=0x0300, mem[0x0310]=0x1234 -> mem[0x0310]=0x3412, R0 incremented by 2, sr_flags_we=0.
4. SXT R3 (0x1183) -> no rf_we and no mem_wr; flags N=0 Z=1 C=0 V=0; done pulses.
5. mem_ack held low 5 cycles in RD -> mem_rd, mem_addr and mem_bw stable throughout. rst asserted in cycle 3 -> immediate IDLE, instr_ready=1, no rf, memory or SR writes afterwards.
6. PUSH (0x1205), then SXT.B R4 (0x11C4) -> each produces a one-cycle illegal pulse, no writes, and instr_ready=1 in the following cycle.
